// File: rtl/gcd_pkg.sv
// Shared GCD definitions: request sequencer state encoding, default widths,
// and the GCD controller's own state encoding.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int GCD_CNT_W = 16;

  typedef logic [1:0] gcd_seq_state_t;

  localparam gcd_seq_state_t S_IDLE    = 2'd0;
  localparam gcd_seq_state_t S_ISSUE   = 2'd1;
  localparam gcd_seq_state_t S_RELEASE = 2'd2;
  localparam gcd_seq_state_t S_RESP    = 2'd3;

  typedef logic [2:0] gcd_ctrl_state_t;

  localparam gcd_ctrl_state_t C_IDLE = 3'd0;
  localparam gcd_ctrl_state_t C_LOAD = 3'd1;
  localparam gcd_ctrl_state_t C_CMP  = 3'd2;
  localparam gcd_ctrl_state_t C_SUB  = 3'd3;
  localparam gcd_ctrl_state_t C_DONE = 3'd4;

endpackage

// File: rtl/gcd_req_seq_if.sv
// Operand stream, GCD go/done handshake and result stream of the request sequencer.
interface gcd_req_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             gcd_go;
  logic [WIDTH-1:0] gcd_x;
  logic [WIDTH-1:0] gcd_y;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [CNT_W-1:0] out_cycles;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    output in_ready, gcd_go, gcd_x, gcd_y, out_valid, out_gcd, out_a, out_b,
           out_cycles, busy
  );

  modport master (
    output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    input  in_ready, gcd_go, gcd_x, gcd_y, out_valid, out_gcd, out_a, out_b,
           out_cycles, busy
  );

endinterface

// File: rtl/gcd_req_fifo.sv
// Operand-pair FIFO with wrap-around pointers; push is refused when full even if
// a pop happens in the same cycle.
module gcd_req_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gcd_req_seq.sv
// Sequences buffered operand pairs through the GCD unit one at a time, resolving
// zero operands locally, and returns result, operands and go-high cycle count.
module gcd_req_seq
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = GCD_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  gcd_req_seq_if.slave bus
);

  gcd_seq_state_t   state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cyc_out;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [2*WIDTH-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  gcd_req_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .wdata ({bus.in_a, bus.in_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a   = fifo_rdata[2*WIDTH-1:WIDTH];
  assign head_b   = fifo_rdata[WIDTH-1:0];
  assign fifo_pop = (state == S_IDLE) && !fifo_empty;
  assign cnt_nxt  = sat_inc(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      cyc_out <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            op_a <= head_a;
            op_b <= head_b;
            cnt  <= '0;
            // A zero operand would never terminate the subtract loop; answer it here.
            if (head_a == '0 || head_b == '0) begin
              res     <= head_a | head_b;
              cyc_out <= '0;
              state   <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt <= cnt_nxt;
          if (bus.gcd_done) begin
            res     <= bus.gcd_result;
            cyc_out <= cnt_nxt;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Controller must be back in idle before the next go can be issued.
          if (!bus.gcd_done) state <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.gcd_go     = (state == S_ISSUE);
  assign bus.gcd_x      = op_a;
  assign bus.gcd_y      = op_b;
  assign bus.out_valid  = (state == S_RESP);
  assign bus.out_gcd    = res;
  assign bus.out_a      = op_a;
  assign bus.out_b      = op_b;
  assign bus.out_cycles = cyc_out;
  assign bus.busy       = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gcd_req_seq.sv
// Directed bench for gcd_req_seq with a subtract-loop GCD controller/datapath attached.
module tb_gcd_req_seq;
  import gcd_pkg::*;

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  c;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int go_cnt   = 0;
  int done_cyc = 0;
  int vrise_cyc = 0;

  res_t res_q[$];
  logic stall_prev = 1'b0;
  logic prev_done  = 1'b0;
  logic prev_valid = 1'b0;
  res_t stall_snap;

  gcd_req_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

  gcd_req_seq #(.WIDTH(16), .DEPTH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // GCD controller/datapath: IDLE -> LOAD -> (CMP -> SUB)* -> CMP -> DONE (one cycle).
  gcd_ctrl_state_t cst;
  logic [15:0] rx, ry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst <= C_IDLE;
      rx  <= '0;
      ry  <= '0;
    end else begin
      case (cst)
        C_IDLE: if (bus.gcd_go) cst <= C_LOAD;
        C_LOAD: begin rx <= bus.gcd_x; ry <= bus.gcd_y; cst <= C_CMP; end
        C_CMP:  cst <= (rx == ry) ? C_DONE : C_SUB;
        C_SUB: begin
          if (rx > ry) rx <= rx - ry;
          else         ry <= ry - rx;
          cst <= C_CMP;
        end
        default: cst <= C_IDLE;
      endcase
    end
  end

  assign bus.gcd_done   = (cst == C_DONE);
  assign bus.gcd_result = rx;

  // Result collector and stall-stability checker, sampled on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      stall_prev = 1'b0;
      prev_done  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.gcd_go) go_cnt++;
      if (bus.gcd_done && !prev_done) done_cyc = ncyc;
      if (bus.out_valid && !prev_valid) vrise_cyc = ncyc;
      if (stall_prev) begin
        n_assert++;
        if (bus.out_valid !== 1'b1 ||
            {bus.out_gcd, bus.out_a, bus.out_b, bus.out_cycles} !== stall_snap) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%0b gcd=%0d a=%0d b=%0d cyc=%0d, required 1 %0d %0d %0d %0d",
                   bus.out_valid, bus.out_gcd, bus.out_a, bus.out_b, bus.out_cycles,
                   stall_snap.g, stall_snap.a, stall_snap.b, stall_snap.c);
        end
      end
      if (bus.out_valid && bus.out_ready)
        res_q.push_back({bus.out_gcd, bus.out_a, bus.out_b, bus.out_cycles});
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_snap = {bus.out_gcd, bus.out_a, bus.out_b, bus.out_cycles};
      prev_done  = bus.gcd_done;
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t get_res();
    if (res_q.size() > 0) return res_q.pop_front();
    return 'x;
  endfunction

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    while (!bus.in_ready && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    n_assert++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_ready: in_ready=%0b after %0d cycles, required 1", bus.in_ready, t);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int t = 0;
    while (res_q.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    n_assert++;
    if (res_q.size() < n) begin
      n_fail++;
      $display("FAIL wait_results: got %0d results, required %0d", res_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({bus.in_ready, bus.gcd_go, bus.out_valid, bus.busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/go/valid/busy=%b, required 1000",
               {bus.in_ready, bus.gcd_go, bus.out_valid, bus.busy});
    end
    n_assert++;
    if ({bus.gcd_x, bus.gcd_y, bus.out_gcd, bus.out_a, bus.out_b, bus.out_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: x=%0d y=%0d gcd=%0d a=%0d b=%0d cyc=%0d, required all 0",
               bus.gcd_x, bus.gcd_y, bus.out_gcd, bus.out_a, bus.out_b, bus.out_cycles);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    res_t r;
    bus.out_ready = 1'b1;
    res_q.delete();
    go_cnt = 0;
    push(16'd12, 16'd18);
    n_assert++;
    if ({bus.gcd_go, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_pop_cycle: go/busy=%b, required 01", {bus.gcd_go, bus.busy});
    end
    @(posedge clk); #1;
    n_assert++;
    if (bus.gcd_go !== 1'b1 || bus.gcd_x !== 16'd12 || bus.gcd_y !== 16'd18) begin
      n_fail++;
      $display("FAIL basic_go_rise: go=%0b x=%0d y=%0d, required 1 12 18", bus.gcd_go, bus.gcd_x, bus.gcd_y);
    end
    wait_res(1, 100);
    r = get_res();
    n_assert++;
    if (r !== {16'd6, 16'd12, 16'd18, 4'd8}) begin
      n_fail++;
      $display("FAIL basic_result: got gcd=%0d a=%0d b=%0d cyc=%0d, required 6 12 18 8", r.g, r.a, r.b, r.c);
    end
    n_assert++;
    if (go_cnt != 8) begin
      n_fail++;
      $display("FAIL basic_go_cycles: got %0d, required 8", go_cnt);
    end
    n_assert++;
    if (vrise_cyc - done_cyc != 2) begin
      n_fail++;
      $display("FAIL basic_done_to_valid: got %0d cycles, required 2", vrise_cyc - done_cyc);
    end
  endtask

  task automatic test_bypass();
    res_t r;
    bus.out_ready = 1'b1;
    res_q.delete();
    go_cnt = 0;
    push(16'd0, 16'd7);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_early: out_valid=%0b one cycle after push, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    n_assert++;
    if (bus.out_valid !== 1'b1 || bus.out_gcd !== 16'd7) begin
      n_fail++;
      $display("FAIL bypass_latency: valid=%0b gcd=%0d two cycles after push, required 1 7", bus.out_valid, bus.out_gcd);
    end
    push(16'd0, 16'd0);
    push(16'd9, 16'd0);
    wait_res(3, 40);
    r = get_res();
    n_assert++;
    if (r !== {16'd7, 16'd0, 16'd7, 4'd0}) begin
      n_fail++;
      $display("FAIL bypass_0_7: got gcd=%0d a=%0d b=%0d cyc=%0d, required 7 0 7 0", r.g, r.a, r.b, r.c);
    end
    r = get_res();
    n_assert++;
    if (r !== {16'd0, 16'd0, 16'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL bypass_0_0: got gcd=%0d a=%0d b=%0d cyc=%0d, required 0 0 0 0", r.g, r.a, r.b, r.c);
    end
    r = get_res();
    n_assert++;
    if (r !== {16'd9, 16'd9, 16'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL bypass_9_0: got gcd=%0d a=%0d b=%0d cyc=%0d, required 9 9 0 0", r.g, r.a, r.b, r.c);
    end
    n_assert++;
    if (go_cnt != 0) begin
      n_fail++;
      $display("FAIL bypass_no_go: gcd_go high %0d cycles, required 0", go_cnt);
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    int ea[5] = '{8, 9, 21, 5, 7};
    int eb[5] = '{4, 3, 14, 5, 1};
    int eg[5] = '{4, 3, 7, 5, 1};
    int ec[5] = '{6, 8, 8, 4, 15};
    bus.out_ready = 1'b0;
    res_q.delete();
    for (int i = 0; i < 5; i++) push(16'(ea[i]), 16'(eb[i]));
    n_assert++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%0b after 5 pushes, required 0", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_a = 16'd99; bus.in_b = 16'd33;
    repeat (6) @(posedge clk);
    #1;
    n_assert++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_held_off: in_ready=%0b while stalled, required 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_res(5, 400);
    repeat (30) @(posedge clk);
    #1;
    n_assert++;
    if (res_q.size() != 5) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 5", res_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      r = get_res();
      n_assert++;
      if (r !== {16'(eg[i]), 16'(ea[i]), 16'(eb[i]), 4'(ec[i])}) begin
        n_fail++;
        $display("FAIL bp_result%0d: got gcd=%0d a=%0d b=%0d cyc=%0d, required %0d %0d %0d %0d",
                 i, r.g, r.a, r.b, r.c, eg[i], ea[i], eb[i], ec[i]);
      end
    end
  endtask

  task automatic test_stall();
    res_t r;
    int i = 0;
    bus.out_ready = 1'b0;
    res_q.delete();
    push(16'd1, 16'd300);
    push(16'd0, 16'd9);
    while (res_q.size() < 2 && i < 3000) begin
      @(posedge clk); #1;
      bus.out_ready = (i % 3 == 2);
      i++;
    end
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_assert++;
    if (res_q.size() != 2) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results, required 2", res_q.size());
    end
    r = get_res();
    n_assert++;
    if (r !== {16'd1, 16'd1, 16'd300, 4'd15}) begin
      n_fail++;
      $display("FAIL stall_sat: got gcd=%0d a=%0d b=%0d cyc=%0d, required 1 1 300 15", r.g, r.a, r.b, r.c);
    end
    r = get_res();
    n_assert++;
    if (r !== {16'd9, 16'd0, 16'd9, 4'd0}) begin
      n_fail++;
      $display("FAIL stall_bypass: got gcd=%0d a=%0d b=%0d cyc=%0d, required 9 0 9 0", r.g, r.a, r.b, r.c);
    end
  endtask

  task automatic test_push_pop();
    res_t r;
    int t = 0;
    int eg[4] = '{4, 3, 7, 5};
    int ea[4] = '{8, 9, 21, 15};
    bus.out_ready = 1'b0;
    res_q.delete();
    push(16'd8, 16'd4);
    push(16'd9, 16'd3);
    push(16'd21, 16'd14);
    while (!bus.out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_assert++;
    if (dut.u_fifo.count !== 3'd2) begin
      n_fail++;
      $display("FAIL pp_count_before: got %0d, required 2", dut.u_fifo.count);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'd15; bus.in_b = 16'd10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_assert++;
    if (dut.u_fifo.count !== 3'd2) begin
      n_fail++;
      $display("FAIL pp_count_after: got %0d, required 2", dut.u_fifo.count);
    end
    bus.out_ready = 1'b1;
    wait_res(4, 300);
    for (int i = 0; i < 4; i++) begin
      r = get_res();
      n_assert++;
      if (r.g !== 16'(eg[i]) || r.a !== 16'(ea[i])) begin
        n_fail++;
        $display("FAIL pp_order%0d: got gcd=%0d a=%0d, required %0d %0d", i, r.g, r.a, eg[i], ea[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    int t = 0;
    bus.out_ready = 1'b1;
    res_q.delete();
    push(16'd100, 16'd75);
    push(16'd3, 16'd3);
    while (!bus.gcd_go && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({bus.in_ready, bus.gcd_go, bus.out_valid, bus.busy} !== 4'b1000 || bus.gcd_x !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: ready/go/valid/busy=%b x=%0d, required 1000 0",
               {bus.in_ready, bus.gcd_go, bus.out_valid, bus.busy}, bus.gcd_x);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push(16'd100, 16'd75);
    wait_res(1, 100);
    repeat (20) @(posedge clk);
    #1;
    n_assert++;
    if (res_q.size() != 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d results, required 1", res_q.size());
    end
    r = get_res();
    n_assert++;
    if (r !== {16'd25, 16'd100, 16'd75, 4'd10}) begin
      n_fail++;
      $display("FAIL midreset_result: got gcd=%0d a=%0d b=%0d cyc=%0d, required 25 100 75 10", r.g, r.a, r.b, r.c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_stall();
    test_push_pop();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
